// File: rtl/rx_pkg.sv
// rx_pkg: shared width helpers, saturation limits and the default coefficient
// vector for the two-lane matched-filter receiver (rx_mf_iq / rx_mf_lane).
package rx_pkg;

  localparam int DEF_NCOEF      = 24;
  localparam int DEF_COEF_NBITS = 8;

  // All-zero tap set; h[0] occupies the most significant COEF_NBITS bits.
  localparam logic [DEF_NCOEF*DEF_COEF_NBITS-1:0] DEF_COEF_INIT = '0;

  // Accumulator width that can hold the sum of NCOEF full products without overflow.
  function automatic int full_n(input int data_nbits, input int coef_nbits, input int ncoef);
    return data_nbits + coef_nbits + $clog2(ncoef);
  endfunction

  function automatic int full_f(input int data_fbits, input int coef_fbits);
    return data_fbits + coef_fbits;
  endfunction

  // Number of LSBs dropped when moving from full precision to the output format.
  function automatic int q_shift(input int full_fbits, input int out_fbits);
    return full_fbits - out_fbits;
  endfunction

  function automatic int sat_max(input int nbits);
    return (2 ** (nbits - 1)) - 1;
  endfunction

  function automatic int sat_min(input int nbits);
    return -(2 ** (nbits - 1));
  endfunction

endpackage

// File: rtl/rx_mf_lane.sv
// rx_mf_lane: one lane of the matched-filter receiver.
// Registered products, registered transposed adder chain, then a quantiser
// and hard decision latched when the top asks for a symbol sample.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   enable     sample strobe; pipeline holds when low
//   x          signed lane input sample
//   coef       active tap bank, h[k] at bits [k*COEF_NBITS +: COEF_NBITS]
//   latch      capture the current filter output on this edge
//   sample     quantised symbol sample
//   hard_bit   1 when the full-precision filter output is >= 0
//   sat        the captured sample was clamped
module rx_mf_lane
  import rx_pkg::*;
#(
  parameter int NCOEF      = DEF_NCOEF,
  parameter int COEF_NBITS = DEF_COEF_NBITS,
  parameter int COEF_FBITS = 7,
  parameter int DATA_NBITS = 8,
  parameter int DATA_FBITS = 7,
  parameter int OUT_NBITS  = 8,
  parameter int OUT_FBITS  = 7,
  parameter int ROUND      = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic signed [DATA_NBITS-1:0]  x,
  input  logic [NCOEF*COEF_NBITS-1:0]   coef,
  input  logic                          latch,
  output logic signed [OUT_NBITS-1:0]   sample,
  output logic                          hard_bit,
  output logic                          sat
);

  localparam int FN      = full_n(DATA_NBITS, COEF_NBITS, NCOEF);
  localparam int FF      = full_f(DATA_FBITS, COEF_FBITS);
  localparam int SHIFT   = q_shift(FF, OUT_FBITS);
  localparam int RW      = FN + 1;
  localparam int PW      = DATA_NBITS + COEF_NBITS;
  localparam int RND_ADD = (ROUND != 0) ? (2 ** SHIFT) / 2 : 0;
  localparam logic [OUT_NBITS-1:0] SAT_MAX = OUT_NBITS'(sat_max(OUT_NBITS));
  localparam logic [OUT_NBITS-1:0] SAT_MIN = OUT_NBITS'(sat_min(OUT_NBITS));

  logic signed [PW-1:0] prod_p0 [NCOEF];
  logic signed [FN-1:0] acc_p1  [NCOEF];

  function automatic logic signed [PW-1:0] mul(input logic signed [DATA_NBITS-1:0] a,
                                               input logic signed [COEF_NBITS-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  // Returns {clamped, value}. Rounding happens one bit wider than the
  // accumulator so adding the half-LSB can never wrap.
  function automatic logic [OUT_NBITS:0] quantise(input logic signed [FN-1:0] y);
    logic signed [RW-1:0]     r;
    logic signed [RW-1:0]     sh;
    logic [RW-OUT_NBITS:0]    upper;
    r     = RW'(y) + RW'(RND_ADD);
    sh    = r >>> SHIFT;
    upper = sh[RW-1:OUT_NBITS-1];
    if ((&upper) || !(|upper)) return {1'b0, sh[OUT_NBITS-1:0]};
    else if (r[RW-1])          return {1'b1, SAT_MIN};
    else                       return {1'b1, SAT_MAX};
  endfunction

  // Stage p0: one registered product per tap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NCOEF; k++) prod_p0[k] <= '0;
    end else if (enable) begin
      for (int k = 0; k < NCOEF; k++)
        prod_p0[k] <= mul(x, $signed(coef[k*COEF_NBITS +: COEF_NBITS]));
    end
  end

  // Stage p1: transposed adder chain; acc_p1[0] is the filter output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NCOEF; k++) acc_p1[k] <= '0;
    end else if (enable) begin
      for (int k = 0; k < NCOEF - 1; k++) acc_p1[k] <= FN'(prod_p0[k]) + acc_p1[k+1];
      acc_p1[NCOEF-1] <= FN'(prod_p0[NCOEF-1]);
    end
  end

  // Stage p2: symbol sample, saturation flag and hard decision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample   <= '0;
      sat      <= 1'b0;
      hard_bit <= 1'b0;
    end else if (latch) begin
      {sat, sample} <= quantise(acc_p1[0]);
      hard_bit      <= ~acc_p1[0][FN-1];
    end
  end

endmodule

// File: rtl/rx_mf_iq.sv
// rx_mf_iq: two-lane (I/Q) matched-filter receiver and symbol sampler.
// Holds the phase counter and the shadow/active coefficient banks shared by
// both lanes; the shadow bank is copied into the active bank only on the
// enabled edge where the phase counter wraps to 0.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   enable                      sample strobe; all sample state holds when low
//   rx_i, rx_q                  signed lane inputs
//   phase_in                    sampling phase within the symbol
//   coef_wr_en/addr/data        shadow bank write port (out-of-range ignored)
//   coef_commit, coef_pending   shadow-to-active copy request and its status
//   rx_out_i/q, rx_bit_i/q      quantised samples and hard decisions
//   sat_i/q                     clamp flags for the current outputs
//   out_valid                   one-cycle strobe for new outputs
module rx_mf_iq
  import rx_pkg::*;
#(
  parameter int UPSAMPLE   = 4,
  parameter int NCOEF      = DEF_NCOEF,
  parameter int COEF_NBITS = DEF_COEF_NBITS,
  parameter int COEF_FBITS = 7,
  parameter int DATA_NBITS = 8,
  parameter int DATA_FBITS = 7,
  parameter int OUT_NBITS  = 8,
  parameter int OUT_FBITS  = 7,
  parameter int ROUND      = 1,
  parameter logic [NCOEF*COEF_NBITS-1:0] COEF_INIT = DEF_COEF_INIT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic signed [DATA_NBITS-1:0]  rx_i,
  input  logic signed [DATA_NBITS-1:0]  rx_q,
  input  logic [$clog2(UPSAMPLE)-1:0]   phase_in,
  input  logic                          coef_wr_en,
  input  logic [$clog2(NCOEF)-1:0]      coef_wr_addr,
  input  logic [COEF_NBITS-1:0]         coef_wr_data,
  input  logic                          coef_commit,
  output logic                          coef_pending,
  output logic signed [OUT_NBITS-1:0]   rx_out_i,
  output logic signed [OUT_NBITS-1:0]   rx_out_q,
  output logic                          rx_bit_i,
  output logic                          rx_bit_q,
  output logic                          out_valid,
  output logic                          sat_i,
  output logic                          sat_q
);

  localparam int PHW = $clog2(UPSAMPLE);

  logic [PHW-1:0]               cnt;
  logic signed [COEF_NBITS-1:0] shd     [NCOEF];
  logic signed [COEF_NBITS-1:0] shd_nxt [NCOEF];
  logic signed [COEF_NBITS-1:0] act     [NCOEF];
  logic [NCOEF*COEF_NBITS-1:0]  coef_flat;
  logic                         wrap;
  logic                         latch;
  logic                         swap;

  assign wrap  = enable && (cnt == PHW'(UPSAMPLE - 1));
  assign latch = enable && (cnt == phase_in);
  assign swap  = wrap && coef_pending;

  // Shadow bank after this cycle's write, so a write landing on the swap
  // edge is still carried into the active bank.
  always_comb begin
    shd_nxt = shd;
    if (coef_wr_en && (int'(coef_wr_addr) < NCOEF)) shd_nxt[coef_wr_addr] = coef_wr_data;
  end

  always_comb begin
    coef_flat = '0;
    for (int k = 0; k < NCOEF; k++) coef_flat[k*COEF_NBITS +: COEF_NBITS] = act[k];
  end

  // Control: phase counter, coefficient banks, commit handshake, strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      coef_pending <= 1'b0;
      out_valid    <= 1'b0;
      for (int k = 0; k < NCOEF; k++) begin
        shd[k] <= COEF_INIT[(NCOEF-1-k)*COEF_NBITS +: COEF_NBITS];
        act[k] <= COEF_INIT[(NCOEF-1-k)*COEF_NBITS +: COEF_NBITS];
      end
    end else begin
      out_valid <= latch;
      shd       <= shd_nxt;
      if (enable) cnt <= cnt + 1'b1;
      if (swap) begin
        act          <= shd_nxt;
        coef_pending <= 1'b0;
      end else if (coef_commit) begin
        coef_pending <= 1'b1;
      end
    end
  end

  rx_mf_lane #(
    .NCOEF(NCOEF), .COEF_NBITS(COEF_NBITS), .COEF_FBITS(COEF_FBITS),
    .DATA_NBITS(DATA_NBITS), .DATA_FBITS(DATA_FBITS),
    .OUT_NBITS(OUT_NBITS), .OUT_FBITS(OUT_FBITS), .ROUND(ROUND)
  ) u_lane_i (
    .clk(clk), .rst(rst), .enable(enable), .x(rx_i), .coef(coef_flat), .latch(latch),
    .sample(rx_out_i), .hard_bit(rx_bit_i), .sat(sat_i)
  );

  rx_mf_lane #(
    .NCOEF(NCOEF), .COEF_NBITS(COEF_NBITS), .COEF_FBITS(COEF_FBITS),
    .DATA_NBITS(DATA_NBITS), .DATA_FBITS(DATA_FBITS),
    .OUT_NBITS(OUT_NBITS), .OUT_FBITS(OUT_FBITS), .ROUND(ROUND)
  ) u_lane_q (
    .clk(clk), .rst(rst), .enable(enable), .x(rx_q), .coef(coef_flat), .latch(latch),
    .sample(rx_out_q), .hard_bit(rx_bit_q), .sat(sat_q)
  );

endmodule

// File: doc/rx_mf_iq.md
Name: rx_mf_iq

Overview:
Parametrised two-lane (I/Q) matched-filter receiver and symbol sampler; the next generation of the single-lane receiver FIR. Each lane runs a pipelined transposed FIR at the upsampled rate and picks one phase per symbol. It quantises with selectable rounding and flagged saturation, and emits a hard bit decision. Coefficients are runtime-loadable through a shadow bank that switches only on a symbol boundary. Sits between the channel/ADC front end and the BER/sync logic.

Parameters:
UPSAMPLE, 4, samples per symbol (power of 2, >=2)
NCOEF, 24, filter taps
COEF_NBITS, 8, signed coefficient width
COEF_FBITS, 7, coefficient fractional bits
DATA_NBITS, 8, signed input width
DATA_FBITS, 7, input fractional bits
OUT_NBITS, 8, output width
OUT_FBITS, 7, output fractional bits (must satisfy OUT_FBITS <= DATA_FBITS+COEF_FBITS)
ROUND, 1, 1 = round half up before saturating, 0 = truncate
COEF_INIT, all zero, NCOEF*COEF_NBITS packed; h[0] in the MSBs

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
enable  in  1  sample strobe; when low, all state holds
rx_i, rx_q  in  DATA_NBITS  signed lane inputs
phase_in  in  clog2(UPSAMPLE)  sampling phase select
coef_wr_en  in  1  write shadow coefficient
coef_wr_addr  in  clog2(NCOEF)  tap index
coef_wr_data  in  COEF_NBITS  coefficient value
coef_commit  in  1  request shadow-to-active copy
coef_pending  out  1  commit requested, not yet applied
rx_out_i, rx_out_q  out  OUT_NBITS  quantised symbol samples
rx_bit_i, rx_bit_q  out  1  hard decisions
out_valid  out  1  one-cycle strobe: new outputs this cycle
sat_i, sat_q  out  1  saturation occurred on the current output

Behaviour:
- Reset (async, rst=0): active and shadow banks <= COEF_INIT. Phase counter, products and accumulators cleared. All outputs 0, coef_pending 0.
- Full precision: FULL_N = DATA_NBITS+COEF_NBITS+clog2(NCOEF); FULL_F = DATA_FBITS+COEF_FBITS. No internal overflow is possible.
- Per lane: y[n] = sum over k of h[k]*x[n-k], counting enabled cycles only.
- Pipeline: registered products, then a registered transposed adder chain. y[n] is ready 2 enabled cycles after x[n] is presented.
- Phase counter advances 0..UPSAMPLE-1 and wraps on each enabled cycle.
- On an enabled cycle with counter==phase_in:
  - next edge latches both lanes' quantised y and the bits;
  - out_valid=1 for that one cycle only;
  - out_valid=0 otherwise, and always 0 when enable=0.
- phase_in is sampled every cycle; changing it mid-symbol can yield 0 or 2 strobes in that symbol, which is legal.
- Quantise:
  - shift = FULL_F-OUT_FBITS.
  - ROUND=1: add 2^(shift-1) in FULL_N+1 bits, then drop shift LSBs.
  - Saturate if the remaining upper bits are not sign extension of bit OUT_NBITS-1: positive -> max (0x7F at 8 bits), negative -> min (0x80).
  - sat_x=1 exactly when clamped; it is registered with the output.
- Bit decision: rx_bit_x = 1 iff full-precision y >= 0 (sign bit of y inverted, before rounding).
- Coefficients:
  - coef_wr_en writes the shadow bank only; out-of-range addresses are ignored.
  - coef_commit sets coef_pending.
  - The copy into the active bank happens on the enabled cycle where the counter wraps to 0; coef_pending clears on that same edge.
  - Write and commit in the same cycle: the write is included.
  - Commit while already pending: no effect.
  - The old taps remain in the pipeline, so the transition produces NCOEF mixed samples; this is accepted.
- Reset mid-operation: immediate clear; pending commit is lost; the shadow bank reverts to COEF_INIT.

Decomposition:
- Package rx_pkg: width helper functions (FULL_N, FULL_F, shift), saturation constants, default coefficient vector.
- Sub-module rx_mf_lane: products, adder chain, quantiser and bit decision for one lane. It is instantiated twice and shares the active bank and the phase counter from the top.

Test Plan:
- COEF_INIT h[0]=0x40, others 0; rx_i=0x7F for one enabled cycle, phase_in=0 -> next strobe gives rx_out_i=0x40 (ROUND=1) or 0x3F (ROUND=0), rx_bit_i=1, sat_i=0.
- All taps 0x7F; rx_i=0x7F held -> rx_out_i=0x7F, sat_i=1, bit 1. Then rx_q=0x80 held -> rx_out_q=0x80, sat_q=1, bit 0.
- Write h[3]=0x20 and commit at counter=2 -> coef_pending high until the wrap to 0; impulse response afterwards shows 0x20 at lag 3.
- Toggle enable 1-0-0-1 during a symbol -> outputs, counter and accumulators frozen; out_valid never 1 while enable=0.
- phase_in swept 0..3 against a known ramp -> latched sample shifts by one input per phase step, with 2-cycle latency.
- Assert rst mid-symbol with commit pending -> all outputs 0 immediately, coef_pending 0, COEF_INIT response restored.
